seq_counter_scheduler: RTL and testbench
========================================

SEQ_COUNTER_SCHEDULER -- requirements
Module: seq_counter_scheduler

Interface
REQ-001 SHALL have no parameters; sequence table and opcodes are fixed package constants.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 clear  in  1  reset, asynchronous, active-high.
REQ-004 cmd_valid  in  1  command present this cycle.
REQ-005 cmd_ready  out  1  command accepted when cmd_valid&cmd_ready at clk edge.
REQ-006 cmd_op  in  2  00 RUN_N, 01 RUN_FREE, 10 STOP, 11 LOAD.
REQ-007 cmd_arg  in  4  step count (RUN_N) or load value (LOAD); ignored otherwise.
REQ-008 pause  in  1  hold q and step count while high.
REQ-009 q  out  4  current sequence-counter state.
REQ-010 busy  out  1  high in RUN_N or RUN_FREE.
REQ-011 done  out  1  one-cycle pulse, RUN_N completed normally.
REQ-012 err  out  1  one-cycle pulse, illegal command or off-sequence load.

Function
REQ-013 Sequence SHALL be 0->5->10->15->3->12->6->9->0 (8 states, wraps); any other value steps to 0.
REQ-014 FSM states SHALL be IDLE, RUN_N, RUN_FREE; registered outputs, no combinational path from inputs to q/done/err.
REQ-015 cmd_ready SHALL be constantly 1 out of reset; every valid command is consumed in one cycle.
REQ-016 IDLE+RUN_N, arg N>0: next state RUN_N, remaining=N; q unchanged on accepting edge.
REQ-017 IDLE+RUN_N, arg 0: stay IDLE, done pulses next cycle, q unchanged.
REQ-018 RUN_N, pause=0: each edge advances q one step, remaining decrements; edge taking remaining 1->0 returns to IDLE and sets done for the following cycle (done coincides with final q).
REQ-019 IDLE+RUN_FREE: next state RUN_FREE; q advances every subsequent edge with pause=0, indefinitely.
REQ-020 pause=1 in RUN_N/RUN_FREE: q, remaining, state hold; no done.
REQ-021 STOP while busy: return to IDLE on accepting edge, no step that edge, no done; STOP beats pause.
REQ-022 STOP in IDLE: no-op, no err.
REQ-023 IDLE+LOAD: q<=cmd_arg next edge; if cmd_arg not in sequence, err pulses same cycle q shows value.
REQ-024 RUN_N, RUN_FREE or LOAD accepted while busy: dropped, state/q/remaining unaffected, err pulses next cycle; run continues (including its step that edge).
REQ-025 remaining SHALL be 4 bits, never underflows; done and err may assert in the same cycle.

Reset
REQ-026 clear=1 SHALL immediately force: state IDLE, q=0, remaining=0, busy=0, done=0, err=0; cmd_ready=0 while clear high.
REQ-027 clear asserted mid-run SHALL abort with no done pulse; after release, block idles until a new command.

Structure
REQ-028 Shared package SHALL hold opcode constants, FSM state encoding, and the 8-entry sequence table.
REQ-029 Next-state function SHALL be sub-module seq_next (4-bit in, 4-bit out, on_seq flag), combinational, reused for load checking.

Verification
REQ-030 Reset, RUN_N arg 3, pause=0 -> q 5,10,15 on three successive edges; done=1 only in cycle q=15; busy falls with done.
REQ-031 LOAD 12, then RUN_N 4 with pause high on second step cycle -> q 6,(hold 6),9,0,5; done once with q=5.
REQ-032 RUN_FREE from q=0 for 10 edges then STOP -> q 5,10,15,3,12,6,9,0,5,10 then holds 10; no done.
REQ-033 LOAD 7 -> q=7, err=1 same cycle; RUN_N 1 -> q=0, done=1.
REQ-034 RUN_N 5 then LOAD 3 mid-run -> err pulse, q sequence uninterrupted, done after fifth step.
REQ-035 clear asserted asynchronously mid-RUN_N at q=15 -> q=0, busy=0 immediately; no done after release.

Source files
------------

// File: rtl/seq_counter_scheduler_pkg.sv
// Shared constants for the sequence-counter scheduler: opcodes, FSM encoding, sequence table.
// Latency: none (declarations only).
// Backpressure: not applicable.
package seq_counter_scheduler_pkg;

  localparam logic [1:0] OP_RUN_N    = 2'b00;
  localparam logic [1:0] OP_RUN_FREE = 2'b01;
  localparam logic [1:0] OP_STOP     = 2'b10;
  localparam logic [1:0] OP_LOAD     = 2'b11;

  localparam int SEQ_LEN = 8;

  // Cyclic sequence; each entry steps to the one after it, the last wraps to the first.
  localparam logic [3:0] SEQ_TABLE [0:SEQ_LEN-1] = '{
    4'd0, 4'd5, 4'd10, 4'd15, 4'd3, 4'd12, 4'd6, 4'd9
  };

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_RUN_N    = 2'b01,
    ST_RUN_FREE = 2'b10
  } state_t;

endpackage

// File: rtl/seq_counter_scheduler_seq_next.sv
// Sequence step function: maps a 4-bit value to its successor and flags table membership.
// Latency: purely combinational.
// Backpressure: not applicable.
module seq_next
  import seq_counter_scheduler_pkg::*;
(
  input  logic [3:0] i_val,
  output logic [3:0] o_next,
  output logic       o_on_seq
);

  // Table lookup; values outside the sequence fall back to the first entry (0).
  always_comb begin
    o_next   = SEQ_TABLE[0];
    o_on_seq = 1'b0;
    for (int i = 0; i < SEQ_LEN; i++) begin
      if (i_val == SEQ_TABLE[3'(i)]) begin
        o_next   = SEQ_TABLE[3'(i + 1)];
        o_on_seq = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_counter_scheduler.sv
// Command-driven sequence counter: bounded/free runs, stop, load, with pause and error reporting.
// Latency: commands take effect on the accepting edge; q/done/err are registered (visible next cycle).
// Backpressure: none; cmd_ready is high whenever clear is low, every valid command is consumed.
module seq_counter_scheduler
  import seq_counter_scheduler_pkg::*;
(
  input  logic       clk,
  input  logic       clear,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_arg,
  input  logic       pause,
  output logic [3:0] q,
  output logic       busy,
  output logic       done,
  output logic       err
);

  state_t     r_state;
  logic [3:0] r_q;
  logic [3:0] r_rem;
  logic       r_done;
  logic       r_err;

  state_t     w_state_nxt;
  logic [3:0] w_q_nxt;
  logic [3:0] w_rem_nxt;
  logic       w_done_nxt;
  logic       w_err_nxt;

  logic       w_acc;
  logic [3:0] w_sn_in;
  logic [3:0] w_sn_next;
  logic       w_sn_on_seq;

  assign cmd_ready = ~clear;
  assign w_acc     = cmd_valid & cmd_ready;

  // One step-function instance: in IDLE it vets a LOAD argument, while running it steps q.
  assign w_sn_in = (r_state == ST_IDLE) ? cmd_arg : r_q;

  seq_next u_seq_next (
    .i_val    (w_sn_in),
    .o_next   (w_sn_next),
    .o_on_seq (w_sn_on_seq)
  );

  // Next-state, next-q, remaining-count and pulse decode.
  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_rem_nxt   = r_rem;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_acc) begin
          case (cmd_op)
            OP_RUN_N: begin
              if (cmd_arg != 4'd0) begin
                w_state_nxt = ST_RUN_N;
                w_rem_nxt   = cmd_arg;
              end else begin
                w_done_nxt = 1'b1;
              end
            end
            OP_RUN_FREE: w_state_nxt = ST_RUN_FREE;
            OP_LOAD: begin
              w_q_nxt   = cmd_arg;
              w_err_nxt = ~w_sn_on_seq;
            end
            default: ;
          endcase
        end
      end
      ST_RUN_N, ST_RUN_FREE: begin
        if (w_acc && cmd_op == OP_STOP) begin
          // STOP wins over pause and suppresses this edge's step.
          w_state_nxt = ST_IDLE;
          w_rem_nxt   = 4'd0;
        end else begin
          // Any other command while running is dropped but flagged.
          w_err_nxt = w_acc;
          if (!pause) begin
            w_q_nxt = w_sn_next;
            if (r_state == ST_RUN_N) begin
              w_rem_nxt = r_rem - 4'd1;
              if (r_rem == 4'd1) begin
                w_state_nxt = ST_IDLE;
                w_done_nxt  = 1'b1;
              end
            end
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_rem_nxt   = 4'd0;
      end
    endcase
  end

  // State and output registers; clear forces the idle/zero state immediately.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_state <= ST_IDLE;
      r_q     <= 4'd0;
      r_rem   <= 4'd0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_rem   <= w_rem_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign q    = r_q;
  assign busy = (r_state != ST_IDLE);
  assign done = r_done;
  assign err  = r_err;

endmodule

// File: tb/tb_seq_counter_scheduler.sv
// Self-checking bench for seq_counter_scheduler: per-scenario stimulus tables feed a scoreboard queue.
// Latency: expected observation is popped one cycle after each stimulus row is driven.
// Backpressure: cmd_ready is checked directly around clear.
module tb_seq_counter_scheduler;

  localparam logic [1:0] OP_RUN_N    = 2'b00;
  localparam logic [1:0] OP_RUN_FREE = 2'b01;
  localparam logic [1:0] OP_STOP     = 2'b10;
  localparam logic [1:0] OP_LOAD     = 2'b11;

  // Stimulus row {valid, op, arg, pause}; expected row {q, busy, done, err}.
  localparam logic [7:0] NOP   = 8'h00;
  localparam logic [7:0] PAUSE = 8'h01;

  logic       clk = 1'b0;
  logic       clear;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_arg;
  logic       pause;
  logic [3:0] q;
  logic       busy;
  logic       done;
  logic       err;

  logic [6:0] sb_q[$];
  int errors = 0;
  int checks = 0;

  seq_counter_scheduler dut (
    .clk       (clk),
    .clear     (clear),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
    .pause     (pause),
    .q         (q),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] cmd(input logic [1:0] op, input logic [3:0] arg, input logic p);
    return {1'b1, op, arg, p};
  endfunction

  function automatic logic [6:0] ex(input logic [3:0] eq, input logic eb, input logic ed, input logic ee);
    return {eq, eb, ed, ee};
  endfunction

  // Drive one stimulus row and advance to just after the next rising edge.
  task automatic tick(input logic [7:0] s);
    {cmd_valid, cmd_op, cmd_arg, pause} = s;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [6:0] exp;
    clear = 1'b1;
    {cmd_valid, cmd_op, cmd_arg, pause} = NOP;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({q, busy, done, err, cmd_ready} !== 8'h00) begin
      errors++;
      $display("FAIL reset: got q=%0d busy=%b done=%b err=%b rdy=%b want all 0", q, busy, done, err, cmd_ready);
    end
    clear = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got rdy=%b want 1", cmd_ready);
    end
    sb_q.push_back(ex(4'd0, 1'b0, 1'b0, 1'b0));
    tick(NOP);
    exp = sb_q.pop_front();
    checks++;
    if ({q, busy, done, err} !== exp) begin
      errors++;
      $display("FAIL reset_idle: got q=%0d b=%b d=%b e=%b want q=%0d b=%b d=%b e=%b",
               q, busy, done, err, exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic test_run_n();
    logic [7:0] st [5];
    logic [6:0] ev [5];
    logic [6:0] exp;
    st = '{cmd(OP_RUN_N, 4'd3, 1'b0), NOP, NOP, NOP, NOP};
    ev = '{ex(0,1,0,0), ex(5,1,0,0), ex(10,1,0,0), ex(15,0,1,0), ex(15,0,0,0)};
    for (int i = 0; i < 5; i++) begin
      sb_q.push_back(ev[i]);
      tick(st[i]);
      exp = sb_q.pop_front();
      checks++;
      if ({q, busy, done, err} !== exp) begin
        errors++;
        $display("FAIL run_n[%0d]: got q=%0d b=%b d=%b e=%b want q=%0d b=%b d=%b e=%b",
                 i, q, busy, done, err, exp[6:3], exp[2], exp[1], exp[0]);
      end
    end
  endtask

  task automatic test_load_pause();
    logic [7:0] st [8];
    logic [6:0] ev [8];
    logic [6:0] exp;
    st = '{cmd(OP_LOAD, 4'd12, 1'b0), cmd(OP_RUN_N, 4'd4, 1'b0), NOP, PAUSE, NOP, NOP, NOP, NOP};
    ev = '{ex(12,0,0,0), ex(12,1,0,0), ex(6,1,0,0), ex(6,1,0,0),
           ex(9,1,0,0), ex(0,1,0,0), ex(5,0,1,0), ex(5,0,0,0)};
    for (int i = 0; i < 8; i++) begin
      sb_q.push_back(ev[i]);
      tick(st[i]);
      exp = sb_q.pop_front();
      checks++;
      if ({q, busy, done, err} !== exp) begin
        errors++;
        $display("FAIL load_pause[%0d]: got q=%0d b=%b d=%b e=%b want q=%0d b=%b d=%b e=%b",
                 i, q, busy, done, err, exp[6:3], exp[2], exp[1], exp[0]);
      end
    end
  endtask

  task automatic test_run_free();
    logic [7:0] st [14];
    logic [6:0] ev [14];
    logic [6:0] exp;
    st = '{cmd(OP_LOAD, 4'd0, 1'b0), cmd(OP_RUN_FREE, 4'd0, 1'b0),
           NOP, NOP, NOP, NOP, NOP, NOP, NOP, NOP, NOP, NOP,
           cmd(OP_STOP, 4'd0, 1'b0), NOP};
    ev = '{ex(0,0,0,0), ex(0,1,0,0),
           ex(5,1,0,0), ex(10,1,0,0), ex(15,1,0,0), ex(3,1,0,0), ex(12,1,0,0),
           ex(6,1,0,0), ex(9,1,0,0), ex(0,1,0,0), ex(5,1,0,0), ex(10,1,0,0),
           ex(10,0,0,0), ex(10,0,0,0)};
    for (int i = 0; i < 14; i++) begin
      sb_q.push_back(ev[i]);
      tick(st[i]);
      exp = sb_q.pop_front();
      checks++;
      if ({q, busy, done, err} !== exp) begin
        errors++;
        $display("FAIL run_free[%0d]: got q=%0d b=%b d=%b e=%b want q=%0d b=%b d=%b e=%b",
                 i, q, busy, done, err, exp[6:3], exp[2], exp[1], exp[0]);
      end
    end
  endtask

  // Off-sequence load, one-step run from it, STOP in idle, zero-length run.
  task automatic test_bad_load();
    logic [7:0] st [6];
    logic [6:0] ev [6];
    logic [6:0] exp;
    st = '{cmd(OP_LOAD, 4'd7, 1'b0), cmd(OP_RUN_N, 4'd1, 1'b0), NOP,
           cmd(OP_STOP, 4'd0, 1'b0), cmd(OP_RUN_N, 4'd0, 1'b0), NOP};
    ev = '{ex(7,0,0,1), ex(7,1,0,0), ex(0,0,1,0), ex(0,0,0,0), ex(0,0,1,0), ex(0,0,0,0)};
    for (int i = 0; i < 6; i++) begin
      sb_q.push_back(ev[i]);
      tick(st[i]);
      exp = sb_q.pop_front();
      checks++;
      if ({q, busy, done, err} !== exp) begin
        errors++;
        $display("FAIL bad_load[%0d]: got q=%0d b=%b d=%b e=%b want q=%0d b=%b d=%b e=%b",
                 i, q, busy, done, err, exp[6:3], exp[2], exp[1], exp[0]);
      end
    end
  endtask

  // Commands dropped while busy, done+err together, STOP overriding pause.
  task automatic test_back_to_back();
    logic [7:0] st [11];
    logic [6:0] ev [11];
    logic [6:0] exp;
    st = '{cmd(OP_RUN_N, 4'd5, 1'b0), NOP, NOP, cmd(OP_LOAD, 4'd3, 1'b0),
           cmd(OP_RUN_FREE, 4'd0, 1'b1), NOP, cmd(OP_RUN_N, 4'd2, 1'b0), NOP,
           cmd(OP_RUN_FREE, 4'd0, 1'b0), cmd(OP_STOP, 4'd0, 1'b1), NOP};
    ev = '{ex(0,1,0,0), ex(5,1,0,0), ex(10,1,0,0), ex(15,1,0,1),
           ex(15,1,0,1), ex(3,1,0,0), ex(12,0,1,1), ex(12,0,0,0),
           ex(12,1,0,0), ex(12,0,0,0), ex(12,0,0,0)};
    for (int i = 0; i < 11; i++) begin
      sb_q.push_back(ev[i]);
      tick(st[i]);
      exp = sb_q.pop_front();
      checks++;
      if ({q, busy, done, err} !== exp) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got q=%0d b=%b d=%b e=%b want q=%0d b=%b d=%b e=%b",
                 i, q, busy, done, err, exp[6:3], exp[2], exp[1], exp[0]);
      end
    end
  endtask

  task automatic test_clear_mid_run();
    logic [7:0] st [5];
    logic [6:0] ev [5];
    logic [6:0] exp;
    st = '{cmd(OP_LOAD, 4'd0, 1'b0), cmd(OP_RUN_N, 4'd5, 1'b0), NOP, NOP, NOP};
    ev = '{ex(0,0,0,0), ex(0,1,0,0), ex(5,1,0,0), ex(10,1,0,0), ex(15,1,0,0)};
    for (int i = 0; i < 5; i++) begin
      sb_q.push_back(ev[i]);
      tick(st[i]);
      exp = sb_q.pop_front();
      checks++;
      if ({q, busy, done, err} !== exp) begin
        errors++;
        $display("FAIL clear_run[%0d]: got q=%0d b=%b d=%b e=%b want q=%0d b=%b d=%b e=%b",
                 i, q, busy, done, err, exp[6:3], exp[2], exp[1], exp[0]);
      end
    end
    #2;
    clear = 1'b1;
    #1;
    checks++;
    if ({q, busy, done, err, cmd_ready} !== 8'h00) begin
      errors++;
      $display("FAIL clear_async: got q=%0d b=%b d=%b e=%b rdy=%b want all 0", q, busy, done, err, cmd_ready);
    end
    @(posedge clk);
    #1;
    clear = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back(ex(0, 0, 0, 0));
      tick(NOP);
      exp = sb_q.pop_front();
      checks++;
      if ({q, busy, done, err} !== exp) begin
        errors++;
        $display("FAIL clear_after[%0d]: got q=%0d b=%b d=%b e=%b want q=%0d b=%b d=%b e=%b",
                 i, q, busy, done, err, exp[6:3], exp[2], exp[1], exp[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_run_n();
    test_load_pause();
    test_run_free();
    test_bad_load();
    test_back_to_back();
    test_clear_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
